// File: rtl/fod_spi_slave.sv
// ---------------------------------------------------------------------------
// fod_spi_slave
//  SPI mode-0 responder that loads the FOD control word set from an external
//  SPI master and holds it as static register outputs for the FOD digital
//  controller. SCS_N/SCLK/SDI are oversampled in the CLK domain through a
//  SYNC_STG-deep synchronizer; all frame handling happens on the synced
//  edges.
//
//  Frame: 16 bits, MSB first: [15]=RW (1=read), [14:8]=addr, [7:0]=data.
//  A write commits one CLK after the 16th synced SCLK rising edge, and
//  CFG_UPD pulses for one cycle in the same cycle the register changes.
//
//  Optional feature macro: FOD_SPI_RDBACK_EN
//   defined   : RW=1 frames shift the addressed register out on SDO during
//               bits 8..15 (SDO changes on synced SCLK falling edges).
//   undefined : no TX path, SDO tied 0; RW=1 frames are discarded.
//
//  Ports
//   CLK, NARST            system clock (>= 4x SCLK), async active-low reset
//   SCS_N, SCLK, SDI      SPI chip select (active low), clock, data in
//   SDO                   serial readback data
//   CFG_UPD               1-cycle pulse per committed write
//   FCW_FOD .. KDTCD_INIT FOD control register outputs
//   DBG_STATE             current frame FSM state (IDLE/CMD/DATA/DONE)
// ---------------------------------------------------------------------------
module fod_spi_slave #(
    parameter int SYNC_STG = 2,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic        CLK,
    input  logic        NARST,
    input  logic        SCS_N,
    input  logic        SCLK,
    input  logic        SDI,
    output logic        SDO,
    output logic        CFG_UPD,
    output logic [22:0] FCW_FOD,
    output logic        PCALI_EN,
    output logic        FREQ_C_EN,
    output logic        FREQ_C_MODE,
    output logic        RT_EN,
    output logic        DTCCALI_EN,
    output logic        OFSTCALI_EN,
    output logic        FCW_DN_EN,
    output logic        SYS_EN,
    output logic        DSM_SYNC_NRST_EN,
    output logic        NCO_SYNC_NRST_EN,
    output logic        FREQ_HOP,
    output logic [1:0]  PSEG,
    output logic [1:0]  CALIORDER,
    output logic [1:0]  FCW_DN_WEIGHT,
    output logic [2:0]  PCALI_FREQDOWN,
    output logic [4:0]  FREQ_C_KS,
    output logic [4:0]  PCALI_KS,
    output logic [4:0]  KB,
    output logic [4:0]  KC,
    output logic [4:0]  KD,
    output logic [9:0]  PHASE_CTRL,
    output logic [9:0]  KDTCB_INIT,
    output logic [9:0]  KDTCC_INIT,
    output logic [9:0]  KDTCD_INIT,
    output logic [1:0]  DBG_STATE
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection.
    // The SCS_N chain resets to 0 (not 1) so that a reset released while
    // SCS_N is already low does not look like a falling edge: a new frame
    // only starts on a genuine high->low transition after reset.
    // ------------------------------------------------------------------
    logic [SYNC_STG-1:0] scs_sync_q, sclk_sync_q, sdi_sync_q;
    logic                scs_prev_q, sclk_prev_q;
    logic                scs_s, sclk_s, sdi_s;
    logic                scs_fall, sclk_rise;

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            scs_sync_q  <= '0;
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            scs_prev_q  <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            scs_sync_q  <= {scs_sync_q[SYNC_STG-2:0], SCS_N};
            sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], SCLK};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STG-2:0], SDI};
            scs_prev_q  <= scs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign scs_s     = scs_sync_q[SYNC_STG-1];
    assign sclk_s    = sclk_sync_q[SYNC_STG-1];
    assign sdi_s     = sdi_sync_q[SYNC_STG-1];
    assign scs_fall  = scs_prev_q & ~scs_s;
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // ------------------------------------------------------------------
    // Frame FSM. rx_q holds the first FRAME_W-1 bits; the last bit is taken
    // straight from sdi_s on the final edge.
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0] rx_q, rx_d;
    logic               wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  fin_addr;

    assign fin_addr = rx_q[FRAME_W-3 -: ADDR_W];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (scs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                end
            end
            ST_CMD: begin
                if (scs_s) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[FRAME_W-3:0], sdi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(ADDR_W)) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (scs_s) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[FRAME_W-3:0], sdi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(FRAME_W - 1)) begin
                        state_d = ST_DONE;
                        // Only mapped write frames produce a commit.
                        if (!rx_q[FRAME_W-2] && (fin_addr <= ADDR_W'(18))) begin
                            wr_pend_d = 1'b1;
                            wr_addr_d = fin_addr;
                            wr_data_d = {rx_q[DATA_W-2:0], sdi_s};
                        end
                    end
                end
            end
            ST_DONE: begin
                if (scs_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign DBG_STATE = state_q;

    // ------------------------------------------------------------------
    // Register bank. FCW bytes 0/1 land in a shadow; byte 2 loads all 23
    // bits at once so the controller never sees a half-updated word.
    // ------------------------------------------------------------------
    logic [22:0] fcw_q;
    logic [7:0]  fcw_sh_lo_q, fcw_sh_mid_q;
    logic        pcali_en_q, freq_c_en_q, freq_c_mode_q, rt_en_q;
    logic        dtccali_en_q, ofstcali_en_q, fcw_dn_en_q;
    logic        sys_en_q, dsm_sync_q, nco_sync_q, freq_hop_q;
    logic [1:0]  pseg_q, caliorder_q, fcw_dn_weight_q;
    logic [2:0]  pcali_freqdown_q;
    logic [4:0]  freq_c_ks_q, pcali_ks_q, kb_q, kc_q, kd_q;
    logic [9:0]  phase_ctrl_q, kdtcb_q, kdtcc_q, kdtcd_q;
    logic        cfg_upd_q;

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            fcw_q            <= 23'h044000;
            fcw_sh_lo_q      <= 8'h00;
            fcw_sh_mid_q     <= 8'h40;
            pcali_en_q       <= 1'b1;
            freq_c_en_q      <= 1'b0;
            freq_c_mode_q    <= 1'b0;
            rt_en_q          <= 1'b1;
            dtccali_en_q     <= 1'b0;
            ofstcali_en_q    <= 1'b0;
            fcw_dn_en_q      <= 1'b1;
            sys_en_q         <= 1'b0;
            dsm_sync_q       <= 1'b1;
            nco_sync_q       <= 1'b1;
            freq_hop_q       <= 1'b0;
            fcw_dn_weight_q  <= 2'd2;
            pseg_q           <= 2'd3;
            caliorder_q      <= 2'd3;
            pcali_freqdown_q <= 3'd0;
            freq_c_ks_q      <= 5'd0;
            pcali_ks_q       <= 5'd8;
            kb_q             <= 5'h00;
            kc_q             <= 5'h1D;
            kd_q             <= 5'h1B;
            phase_ctrl_q     <= 10'd0;
            kdtcb_q          <= 10'd351;
            kdtcc_q          <= 10'd195;
            kdtcd_q          <= 10'd0;
            cfg_upd_q        <= 1'b0;
        end else begin
            cfg_upd_q <= wr_pend_q;
            if (wr_pend_q) begin
                case (wr_addr_q)
                    7'h00: fcw_sh_lo_q  <= wr_data_q;
                    7'h01: fcw_sh_mid_q <= wr_data_q;
                    7'h02: fcw_q        <= {wr_data_q[6:0], fcw_sh_mid_q, fcw_sh_lo_q};
                    7'h03: {fcw_dn_en_q, ofstcali_en_q, dtccali_en_q, rt_en_q,
                            freq_c_mode_q, freq_c_en_q, pcali_en_q} <= wr_data_q[6:0];
                    7'h04: {sys_en_q, dsm_sync_q, nco_sync_q, freq_hop_q,
                            fcw_dn_weight_q, pseg_q} <= wr_data_q;
                    7'h05: {caliorder_q, pcali_freqdown_q} <= wr_data_q[4:0];
                    7'h06: freq_c_ks_q  <= wr_data_q[4:0];
                    7'h07: pcali_ks_q   <= wr_data_q[4:0];
                    7'h08: kb_q         <= wr_data_q[4:0];
                    7'h09: kc_q         <= wr_data_q[4:0];
                    7'h0A: kd_q         <= wr_data_q[4:0];
                    7'h0B: phase_ctrl_q[7:0] <= wr_data_q;
                    7'h0C: phase_ctrl_q[9:8] <= wr_data_q[1:0];
                    7'h0D: kdtcb_q[7:0] <= wr_data_q;
                    7'h0E: kdtcb_q[9:8] <= wr_data_q[1:0];
                    7'h0F: kdtcc_q[7:0] <= wr_data_q;
                    7'h10: kdtcc_q[9:8] <= wr_data_q[1:0];
                    7'h11: kdtcd_q[7:0] <= wr_data_q;
                    7'h12: kdtcd_q[9:8] <= wr_data_q[1:0];
                    default: ;
                endcase
            end
        end
    end

    assign CFG_UPD          = cfg_upd_q;
    assign FCW_FOD          = fcw_q;
    assign PCALI_EN         = pcali_en_q;
    assign FREQ_C_EN        = freq_c_en_q;
    assign FREQ_C_MODE      = freq_c_mode_q;
    assign RT_EN            = rt_en_q;
    assign DTCCALI_EN       = dtccali_en_q;
    assign OFSTCALI_EN      = ofstcali_en_q;
    assign FCW_DN_EN        = fcw_dn_en_q;
    assign SYS_EN           = sys_en_q;
    assign DSM_SYNC_NRST_EN = dsm_sync_q;
    assign NCO_SYNC_NRST_EN = nco_sync_q;
    assign FREQ_HOP         = freq_hop_q;
    assign PSEG             = pseg_q;
    assign CALIORDER        = caliorder_q;
    assign FCW_DN_WEIGHT    = fcw_dn_weight_q;
    assign PCALI_FREQDOWN   = pcali_freqdown_q;
    assign FREQ_C_KS        = freq_c_ks_q;
    assign PCALI_KS         = pcali_ks_q;
    assign KB               = kb_q;
    assign KC               = kc_q;
    assign KD               = kd_q;
    assign PHASE_CTRL       = phase_ctrl_q;
    assign KDTCB_INIT       = kdtcb_q;
    assign KDTCC_INIT       = kdtcc_q;
    assign KDTCD_INIT       = kdtcd_q;

`ifdef FOD_SPI_RDBACK_EN
    // ------------------------------------------------------------------
    // Readback path. The addressed byte is captured on the 8th rising edge
    // (end of the command byte); each synced falling edge in DATA presents
    // the next bit so the master can sample it on the following rise.
    // FCW addresses return the live word, never the shadow.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_q;
    logic              sdo_q;
    logic              sclk_fall;
    logic              tx_load;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] rd_data;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cmd_addr  = {rx_q[ADDR_W-2:0], sdi_s};
    assign tx_load   = (state_q == ST_CMD) && !scs_s && sclk_rise &&
                       (bit_cnt_q == 5'(ADDR_W));

    always_comb begin
        rd_data = '0;
        case (cmd_addr)
            7'h00: rd_data = fcw_q[7:0];
            7'h01: rd_data = fcw_q[15:8];
            7'h02: rd_data = {1'b0, fcw_q[22:16]};
            7'h03: rd_data = {1'b0, fcw_dn_en_q, ofstcali_en_q, dtccali_en_q, rt_en_q,
                              freq_c_mode_q, freq_c_en_q, pcali_en_q};
            7'h04: rd_data = {sys_en_q, dsm_sync_q, nco_sync_q, freq_hop_q,
                              fcw_dn_weight_q, pseg_q};
            7'h05: rd_data = {3'b000, caliorder_q, pcali_freqdown_q};
            7'h06: rd_data = {3'b000, freq_c_ks_q};
            7'h07: rd_data = {3'b000, pcali_ks_q};
            7'h08: rd_data = {3'b000, kb_q};
            7'h09: rd_data = {3'b000, kc_q};
            7'h0A: rd_data = {3'b000, kd_q};
            7'h0B: rd_data = phase_ctrl_q[7:0];
            7'h0C: rd_data = {6'b0, phase_ctrl_q[9:8]};
            7'h0D: rd_data = kdtcb_q[7:0];
            7'h0E: rd_data = {6'b0, kdtcb_q[9:8]};
            7'h0F: rd_data = kdtcc_q[7:0];
            7'h10: rd_data = {6'b0, kdtcc_q[9:8]};
            7'h11: rd_data = kdtcd_q[7:0];
            7'h12: rd_data = {6'b0, kdtcd_q[9:8]};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            tx_q  <= '0;
            sdo_q <= 1'b0;
        end else if (tx_load) begin
            // Write frames load zero so SDO stays quiet during their data.
            tx_q  <= rx_q[ADDR_W-1] ? rd_data : '0;
            sdo_q <= 1'b0;
        end else if (state_q != ST_DATA) begin
            sdo_q <= 1'b0;
        end else if (sclk_fall) begin
            sdo_q <= tx_q[DATA_W-1];
            tx_q  <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    assign SDO = sdo_q & (state_q == ST_DATA) & ~scs_s;
`else
    assign SDO = 1'b0;
`endif

endmodule

// File: tb/tb_fod_spi_slave.sv
module tb_fod_spi_slave;

    localparam time HALF = 60ns;

    logic        CLK = 1'b0;
    logic        NARST = 1'b0;
    logic        SCS_N = 1'b1;
    logic        SCLK = 1'b0;
    logic        SDI = 1'b0;
    logic        SDO, CFG_UPD;
    logic [22:0] FCW_FOD;
    logic        PCALI_EN, FREQ_C_EN, FREQ_C_MODE, RT_EN, DTCCALI_EN, OFSTCALI_EN, FCW_DN_EN;
    logic        SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP;
    logic [1:0]  PSEG, CALIORDER, FCW_DN_WEIGHT;
    logic [2:0]  PCALI_FREQDOWN;
    logic [4:0]  FREQ_C_KS, PCALI_KS, KB, KC, KD;
    logic [9:0]  PHASE_CTRL, KDTCB_INIT, KDTCC_INIT, KDTCD_INIT;
    logic [1:0]  DBG_STATE;

    fod_spi_slave dut (
        .CLK(CLK), .NARST(NARST), .SCS_N(SCS_N), .SCLK(SCLK), .SDI(SDI),
        .SDO(SDO), .CFG_UPD(CFG_UPD), .FCW_FOD(FCW_FOD),
        .PCALI_EN(PCALI_EN), .FREQ_C_EN(FREQ_C_EN), .FREQ_C_MODE(FREQ_C_MODE),
        .RT_EN(RT_EN), .DTCCALI_EN(DTCCALI_EN), .OFSTCALI_EN(OFSTCALI_EN),
        .FCW_DN_EN(FCW_DN_EN), .SYS_EN(SYS_EN), .DSM_SYNC_NRST_EN(DSM_SYNC_NRST_EN),
        .NCO_SYNC_NRST_EN(NCO_SYNC_NRST_EN), .FREQ_HOP(FREQ_HOP), .PSEG(PSEG),
        .CALIORDER(CALIORDER), .FCW_DN_WEIGHT(FCW_DN_WEIGHT),
        .PCALI_FREQDOWN(PCALI_FREQDOWN), .FREQ_C_KS(FREQ_C_KS), .PCALI_KS(PCALI_KS),
        .KB(KB), .KC(KC), .KD(KD), .PHASE_CTRL(PHASE_CTRL), .KDTCB_INIT(KDTCB_INIT),
        .KDTCC_INIT(KDTCC_INIT), .KDTCD_INIT(KDTCD_INIT), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock ----------------
    always #5ns CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    // entry = {sel[7:0], old[23:0], new[23:0]}
    logic [55:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_upd = 0;
    int          seen_upd = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [23:0] get_val(input logic [7:0] sel);
        case (sel)
            8'd0: get_val = {1'b0, FCW_FOD};
            8'd1: get_val = {19'd0, KB};
            8'd2: get_val = {19'd0, KD};
            8'd3: get_val = {19'd0, PCALI_KS};
            8'd4: get_val = {17'd0, FCW_DN_EN, OFSTCALI_EN, DTCCALI_EN, RT_EN,
                             FREQ_C_MODE, FREQ_C_EN, PCALI_EN};
            8'd6: get_val = {14'd0, KDTCD_INIT};
            default: get_val = 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [7:0] rd_exp(input logic [7:0] v);
`ifdef FOD_SPI_RDBACK_EN
        rd_exp = v;
`else
        rd_exp = 8'h00 & v;
`endif
    endfunction

    // ---------------- monitor ----------------
    logic [23:0] prev_v = '0;
    logic        prev_upd = 1'b0;

    always @(negedge CLK) begin
        logic [55:0] e;
        if (!NARST) begin
            prev_upd = 1'b0;
        end else begin
            if (CFG_UPD) begin
                seen_upd++;
                check("cfg_upd_width", {31'd0, prev_upd}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cfg_upd: got=1 expected=0 @%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("commit_new_sel%0d", e[55:48]), {8'd0, get_val(e[55:48])}, {8'd0, e[23:0]});
                    check($sformatf("commit_old_sel%0d", e[55:48]), {8'd0, prev_v}, {8'd0, e[47:24]});
                end
            end
            if (exp_q.size() > 0) prev_v = get_val(exp_q[0][55:48]);
            prev_upd = CFG_UPD;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                             input int nbits, input int rst_bit, output logic [7:0] rd);
        logic [15:0] frame;
        frame = {rw, addr, data};
        rd = 8'h00;
        SCS_N = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            SDI = frame[15-i];
            #HALF;
            if (i >= 8) rd = {rd[6:0], SDO};
            SCLK = 1'b1;
            #HALF;
            SCLK = 1'b0;
            if (i == rst_bit) begin
                NARST = 1'b0;
                #20ns;
                NARST = 1'b1;
            end
        end
        #HALF;
        SCS_N = 1'b1;
        SDI = 1'b0;
        repeat (20) @(posedge CLK);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] data,
                            input logic [7:0] sel, input logic [23:0] oldv, input logic [23:0] newv);
        logic [7:0] rd;
        exp_q.push_back({sel, oldv, newv});
        exp_upd++;
        spi_frame(1'b0, addr, data, 16, -1, rd);
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [7:0] want);
        logic [7:0] rd;
        spi_frame(1'b1, addr, 8'hA5, 16, -1, rd);
        check($sformatf("read_%02h", addr), {24'd0, rd}, {24'd0, rd_exp(want)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd;
        repeat (5) @(posedge CLK);
        #3ns NARST = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("rst_fcw",     {9'd0, FCW_FOD},     32'h044000);
        check("rst_kc",      {27'd0, KC},         32'h1D);
        check("rst_kd",      {27'd0, KD},         32'h1B);
        check("rst_kdtcb",   {22'd0, KDTCB_INIT}, 32'd351);
        check("rst_kdtcc",   {22'd0, KDTCC_INIT}, 32'd195);
        check("rst_pcaliks", {27'd0, PCALI_KS},   32'd8);
        check("rst_reg04",   {24'd0, SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP,
                              FCW_DN_WEIGHT, PSEG}, 32'h6B);
        check("rst_sdo",     {31'd0, SDO},        32'd0);
        check("rst_cfg_upd", {31'd0, CFG_UPD},    32'd0);
        check("rst_state",   {30'd0, DBG_STATE},  32'd0);

        do_write(7'h08, 8'h1F, 8'd1, 24'h00, 24'h1F);
        do_write(7'h00, 8'h00, 8'd0, 24'h044000, 24'h044000);
        do_write(7'h01, 8'h80, 8'd0, 24'h044000, 24'h044000);
        do_write(7'h02, 8'h06, 8'd0, 24'h044000, 24'h068000);

        spi_frame(1'b0, 7'h07, 8'h03, 10, -1, rd);   // aborted after 10 bits
        check("abort_pcaliks", {27'd0, PCALI_KS}, 32'd8);
        do_write(7'h07, 8'h0C, 8'd3, 24'h08, 24'h0C);

        do_write(7'h03, 8'hFF, 8'd4, 24'h49, 24'h7F);
        spi_frame(1'b0, 7'h13, 8'h55, 16, -1, rd);   // unmapped: no commit
        do_write(7'h12, 8'h03, 8'd6, 24'h000, 24'h300);

        do_read(7'h0D, 8'h5F);
        do_read(7'h03, 8'h7F);
        do_read(7'h02, 8'h06);
        do_read(7'h00, 8'h00);
        do_read(7'h09, 8'h1D);
        do_read(7'h7F, 8'h00);

        spi_frame(1'b0, 7'h0A, 8'h11, 16, 12, rd);   // reset pulsed during bit 12
        check("midrst_kd",    {27'd0, KD},      32'h1B);
        check("midrst_kb",    {27'd0, KB},      32'h00);
        check("midrst_fcw",   {9'd0, FCW_FOD},  32'h044000);
        check("midrst_state", {30'd0, DBG_STATE}, 32'd0);
        do_write(7'h0A, 8'h03, 8'd2, 24'h1B, 24'h03);

        repeat (10) @(posedge CLK);
        check("upd_count",  seen_upd, exp_upd);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
